// File: rtl/axi_uart_hub_if.sv
// rtl/axi_uart_hub_if.sv - AXI4-Lite bus bundle between interconnect and the UART hub
interface axi_uart_hub_if #(
    parameter int ADDR_W = 32
) ();
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic              bvalid;
    logic [1:0]        bresp;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bvalid, bresp, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bvalid, bresp, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_uart_hub.sv
// rtl/axi_uart_hub.sv - AXI4-Lite front-end fanning out to N_CH 8-bit UART register buses
module axi_uart_hub #(
    parameter int N_CH   = 4,
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    axi_uart_hub_if.slave        s,
    output logic [N_CH-1:0]      reg_wr,
    output logic [N_CH-1:0]      reg_rd,
    output logic [2:0]           reg_addr,
    output logic [7:0]           reg_wdata,
    input  logic [N_CH*8-1:0]    reg_rdata,
    input  logic [N_CH-1:0]      ch_irq,
    output logic                 irq,
    output logic                 irq_n
);
    localparam int CH_BITS = $clog2(N_CH + 1);
    localparam int AF_W    = CH_BITS + 3;
    localparam logic [CH_BITS-1:0] GPAGE = CH_BITS'(N_CH);

    logic            en_q, en_d;
    logic            aw_full_q, aw_full_d, w_full_q, w_full_d;
    logic [AF_W-1:0] aw_a_q, aw_a_d, ar_a_q, ar_a_d;
    logic [7:0]      w_byte_q, w_byte_d;
    logic            w_strb_q, w_strb_d;
    logic            bvalid_q, bvalid_d;
    logic [1:0]      bresp_q, bresp_d, rresp_q, rresp_d;
    logic [N_CH-1:0] mask_q, mask_d;
    logic            ar_busy_q, ar_busy_d, rd_done_q, rd_done_d, rd_cap_q, rd_cap_d;
    logic            rvalid_q, rvalid_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            irq_q, irq_d;

    logic [CH_BITS-1:0] wr_page, rd_page;
    logic [2:0]         wr_off, rd_off;
    logic               wr_go, rd_go, aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic [7:0]         rd_byte;
    logic               unused_ok;

    assign unused_ok = ^{s.awaddr, s.araddr, s.wdata, s.wstrb};

    assign s.awready = en_q & ~aw_full_q;
    assign s.wready  = en_q & ~w_full_q;
    assign s.arready = en_q & ~ar_busy_q;
    assign s.bvalid  = bvalid_q;
    assign s.bresp   = bresp_q;
    assign s.rvalid  = rvalid_q;
    assign s.rresp   = rresp_q;
    assign s.rdata   = {24'h0, rdata_q};
    assign irq       = irq_q;
    assign irq_n     = ~irq_q;

    always_comb begin
        wr_page = aw_a_q[AF_W-1:3];
        wr_off  = aw_a_q[2:0];
        rd_page = ar_a_q[AF_W-1:3];
        rd_off  = ar_a_q[2:0];
        aw_hs   = s.awvalid & s.awready;
        w_hs    = s.wvalid & s.wready;
        ar_hs   = s.arvalid & s.arready;
        b_hs    = bvalid_q & s.bready;
        r_hs    = rvalid_q & s.rready;
        // A write issuing this cycle pushes any pending read strobe one cycle later
        wr_go   = aw_full_q & w_full_q & ~bvalid_q;
        rd_go   = ar_busy_q & ~rd_done_q & ~wr_go;

        rd_byte = 8'h00;
        if (rd_page < GPAGE) begin
            for (int i = 0; i < N_CH; i++)
                if (rd_page == CH_BITS'(i)) rd_byte = reg_rdata[i*8 +: 8];
        end else if (rd_page == GPAGE) begin
            if (rd_off == 3'd0) rd_byte = 8'(ch_irq & mask_q);
            else if (rd_off == 3'd1) rd_byte = 8'(mask_q);
        end

        reg_wr    = (wr_go && w_strb_q && wr_page < GPAGE) ? (N_CH'(1) << wr_page) : '0;
        reg_rd    = (rd_go && rd_page < GPAGE) ? (N_CH'(1) << rd_page) : '0;
        reg_addr  = wr_go ? wr_off : (rd_go ? rd_off : 3'd0);
        reg_wdata = wr_go ? w_byte_q : 8'h00;

        en_d      = 1'b1;
        aw_full_d = aw_full_q;
        aw_a_d    = aw_a_q;
        w_full_d  = w_full_q;
        w_byte_d  = w_byte_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        mask_d    = mask_q;
        ar_busy_d = ar_busy_q;
        ar_a_d    = ar_a_q;
        rd_done_d = rd_done_q;
        rd_cap_d  = rd_go;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        irq_d     = |(ch_irq & mask_q);

        if (wr_go) aw_full_d = 1'b0;
        else if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_a_d    = s.awaddr[AF_W+1:2];
        end
        if (wr_go) w_full_d = 1'b0;
        else if (w_hs) begin
            w_full_d = 1'b1;
            w_byte_d = s.wdata[7:0];
            w_strb_d = s.wstrb[0];
        end

        if (wr_go) begin
            bvalid_d = 1'b1;
            bresp_d  = (wr_page > GPAGE) ? 2'b10 : 2'b00;
            if (w_strb_q && wr_page == GPAGE && wr_off == 3'd1) mask_d = w_byte_q[N_CH-1:0];
        end else if (b_hs) begin
            bvalid_d = 1'b0;
        end

        if (ar_hs) begin
            ar_busy_d = 1'b1;
            ar_a_d    = s.araddr[AF_W+1:2];
        end else if (r_hs) begin
            ar_busy_d = 1'b0;
        end
        if (rd_go) rd_done_d = 1'b1;
        else if (r_hs) rd_done_d = 1'b0;

        // Channel byte is only valid the cycle after reg_rd, so capture one cycle late
        if (rd_cap_q) begin
            rvalid_d = 1'b1;
            rresp_d  = (rd_page > GPAGE) ? 2'b10 : 2'b00;
            rdata_d  = rd_byte;
        end else if (r_hs) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q      <= 1'b0;
            aw_full_q <= 1'b0;
            aw_a_q    <= '0;
            w_full_q  <= 1'b0;
            w_byte_q  <= 8'h00;
            w_strb_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            mask_q    <= '1;
            ar_busy_q <= 1'b0;
            ar_a_q    <= '0;
            rd_done_q <= 1'b0;
            rd_cap_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= 8'h00;
            irq_q     <= 1'b0;
        end else begin
            en_q      <= en_d;
            aw_full_q <= aw_full_d;
            aw_a_q    <= aw_a_d;
            w_full_q  <= w_full_d;
            w_byte_q  <= w_byte_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            mask_q    <= mask_d;
            ar_busy_q <= ar_busy_d;
            ar_a_q    <= ar_a_d;
            rd_done_q <= rd_done_d;
            rd_cap_q  <= rd_cap_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
        end
    end
endmodule

// File: tb/tb_axi_uart_hub.sv
// tb/tb_axi_uart_hub.sv - directed self-checking bench for axi_uart_hub
module tb_axi_uart_hub;
    localparam int N_CH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_uart_hub_if #(.ADDR_W(32)) bus ();

    logic [N_CH-1:0]   reg_wr, reg_rd, ch_irq;
    logic [2:0]        reg_addr;
    logic [7:0]        reg_wdata;
    logic [N_CH*8-1:0] reg_rdata;
    logic              irq, irq_n;

    axi_uart_hub #(.N_CH(N_CH), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .s(bus),
        .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .ch_irq(ch_irq), .irq(irq), .irq_n(irq_n)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0, wr_cnt = 0, rd_cnt = 0, wr_cyc = 0, rd_cyc = 0;
    logic [3:0] last_wr, last_rd;
    logic [2:0] last_waddr, last_raddr;
    logic [7:0] last_wdata;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (|reg_wr) begin
            wr_cnt <= wr_cnt + 1; wr_cyc <= cyc;
            last_wr <= reg_wr; last_waddr <= reg_addr; last_wdata <= reg_wdata;
        end
        if (|reg_rd) begin
            rd_cnt <= rd_cnt + 1; rd_cyc <= cyc;
            last_rd <= reg_rd; last_raddr <= reg_addr;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200us");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [7:0] d, input logic [3:0] st,
                             input logic [1:0] exp_resp, input string tag);
        int n;
        logic aw_ok, w_ok;
        bus.awaddr = a; bus.awvalid = 1'b1;
        bus.wdata = {24'h0, d}; bus.wstrb = st; bus.wvalid = 1'b1;
        bus.bready = 1'b1;
        n = 0;
        while ((bus.awvalid || bus.wvalid) && n < 20) begin
            aw_ok = bus.awready; w_ok = bus.wready;
            tick(); n++;
            if (aw_ok) bus.awvalid = 1'b0;
            if (w_ok) bus.wvalid = 1'b0;
        end
        n = 0;
        while (!bus.bvalid && n < 20) begin tick(); n++; end
        chk({tag, "_bvalid"}, bus.bvalid, 1'b1);
        chk({tag, "_bresp"}, bus.bresp, exp_resp);
        tick();
        bus.bready = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, input int hold, input logic [31:0] exp_d,
                            input logic [1:0] exp_resp, input string tag);
        int n;
        bus.araddr = a; bus.arvalid = 1'b1;
        n = 0;
        while (!bus.arready && n < 20) begin tick(); n++; end
        tick();
        bus.arvalid = 1'b0;
        n = 0;
        while (!bus.rvalid && n < 20) begin tick(); n++; end
        chk({tag, "_rvalid"}, bus.rvalid, 1'b1);
        chk({tag, "_rdata"}, bus.rdata, exp_d);
        chk({tag, "_rresp"}, bus.rresp, exp_resp);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_rdata_hold"}, bus.rdata, exp_d);
            chk({tag, "_rvalid_hold"}, bus.rvalid, 1'b1);
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
    endtask

    int c0, wr0, rd0, b_n, r_n;
    logic [1:0] bresp_s, rresp_s;
    logic [31:0] rdata_s;

    initial begin
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        ch_irq = '0;
        reg_rdata = {8'h33, 8'h22, 8'h5A, 8'h11};

        // reset held three cycles
        tick(); tick(); tick();
        chk("rst_awready", bus.awready, 1'b0);
        chk("rst_wready", bus.wready, 1'b0);
        chk("rst_arready", bus.arready, 1'b0);
        chk("rst_bvalid", bus.bvalid, 1'b0);
        chk("rst_rvalid", bus.rvalid, 1'b0);
        chk("rst_irq", irq, 1'b0);
        chk("rst_irq_n", irq_n, 1'b1);
        chk("rst_rdata", bus.rdata, 32'h0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", {bus.awready, bus.wready, bus.arready}, 3'b111);
        axi_read(32'h84, 0, 32'h0F, 2'b00, "mask_rst");

        // W one cycle ahead of AW, channel 2 offset 0
        bus.bready = 1'b1;
        bus.wdata = 32'h41; bus.wstrb = 4'h1; bus.wvalid = 1'b1;
        chk("w_first_wready", bus.wready, 1'b1);
        tick();
        bus.wvalid = 1'b0;
        bus.awaddr = 32'h40; bus.awvalid = 1'b1;
        chk("w_first_awready", bus.awready, 1'b1);
        tick();
        bus.awvalid = 1'b0;
        for (int i = 0; i < 20 && !bus.bvalid; i++) tick();
        chk("w_first_bvalid", bus.bvalid, 1'b1);
        chk("w_first_bresp", bus.bresp, 2'b00);
        tick();
        bus.bready = 1'b0;
        chk("w_first_cnt", wr_cnt, 1);
        chk("w_first_strobe", last_wr, 4'b0100);
        chk("w_first_addr", last_waddr, 3'd0);
        chk("w_first_data", last_wdata, 8'h41);

        // read channel 1 with rready held low five cycles
        axi_read(32'h20, 5, 32'h5A, 2'b00, "rd_ch1");
        tick(); tick();
        chk("rd_ch1_cnt", rd_cnt, 1);
        chk("rd_ch1_strobe", last_rd, 4'b0010);
        chk("rd_ch1_addr", last_raddr, 3'd0);

        // unmapped page 5
        wr0 = wr_cnt; rd0 = rd_cnt;
        axi_write(32'hA0, 8'h12, 4'h1, 2'b10, "unmap_wr");
        axi_read(32'hA0, 0, 32'h0, 2'b10, "unmap_rd");
        chk("unmap_no_wr", wr_cnt, wr0);
        chk("unmap_no_rd", rd_cnt, rd0);

        // same-cycle write to ch0 offset 1 and read of ch3
        bus.awaddr = 32'h04; bus.awvalid = 1'b1;
        bus.wdata = 32'h77; bus.wstrb = 4'h1; bus.wvalid = 1'b1;
        bus.araddr = 32'h60; bus.arvalid = 1'b1;
        chk("same_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
        c0 = cyc;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        bus.bready = 1'b1; bus.rready = 1'b1;
        b_n = 0; r_n = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.bvalid) begin b_n++; bresp_s = bus.bresp; end
            if (bus.rvalid) begin r_n++; rresp_s = bus.rresp; rdata_s = bus.rdata; end
            tick();
        end
        bus.bready = 1'b0; bus.rready = 1'b0;
        chk("same_wr_cyc", wr_cyc, c0 + 1);
        chk("same_rd_cyc", rd_cyc, c0 + 2);
        chk("same_wr_strobe", last_wr, 4'b0001);
        chk("same_wr_addr", last_waddr, 3'd1);
        chk("same_wr_data", last_wdata, 8'h77);
        chk("same_rd_strobe", last_rd, 4'b1000);
        chk("same_b_count", b_n, 1);
        chk("same_r_count", r_n, 1);
        chk("same_bresp", bresp_s, 2'b00);
        chk("same_rresp", rresp_s, 2'b00);
        chk("same_rdata", rdata_s, 32'h33);

        // wstrb[0] clear: no strobe, no mask change
        wr0 = wr_cnt;
        axi_write(32'h00, 8'h55, 4'hE, 2'b00, "nostrb_ch");
        axi_write(32'h84, 8'h00, 4'hE, 2'b00, "nostrb_mask");
        chk("nostrb_no_wr", wr_cnt, wr0);
        axi_read(32'h84, 0, 32'h0F, 2'b00, "nostrb_mask_rd");

        // interrupt masking
        ch_irq = 4'b1000;
        tick(); tick();
        chk("irq_on", irq, 1'b1);
        axi_read(32'h80, 0, 32'h08, 2'b00, "status_on");
        axi_write(32'h84, 8'h07, 4'h1, 2'b00, "mask07");
        chk("irq_masked", irq, 1'b0);
        chk("irq_n_masked", irq_n, 1'b1);
        axi_read(32'h80, 0, 32'h00, 2'b00, "status_masked");
        axi_read(32'h84, 0, 32'h07, 2'b00, "mask_rd07");
        axi_write(32'h84, 8'h0F, 4'h1, 2'b00, "mask0f");
        chk("irq_back", irq, 1'b1);
        chk("irq_n_back", irq_n, 1'b0);

        // reset in the middle of a half-accepted write
        axi_write(32'h84, 8'h03, 4'h1, 2'b00, "mask03");
        chk("irq_pre_rst", irq, 1'b0);
        bus.awaddr = 32'h00; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        chk("mid_aw_full", bus.awready, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_wready", bus.wready, 1'b0);
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("mid_awready_clear", bus.awready, 1'b1);
        chk("mid_irq_mask_reset", irq, 1'b1);
        wr0 = wr_cnt;
        bus.wdata = 32'h99; bus.wstrb = 4'h1; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_no_wr", wr_cnt, wr0);
        chk("mid_no_bvalid", bus.bvalid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
